ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that drives the open-collector `ps2c`/`ps2d` pair to send one command byte, for example 0xF4 "enable data reporting" or 0xFF "reset", to the attached mouse or keyboard. It sits beside the PS/2 receivers on the bidirectional A port and shares the same two wires. While a transmission is in progress (`tx_idle` low), the receiver must be gated off.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_clk_filter.sv | 53 +++++
 rtl/ps2_host_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter and its receivers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    ACK   = 3'd4
  } state_e;

  localparam int STOP_EDGE = 10;
  localparam int ACK_EDGE  = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-FF synchronizer, run-length glitch filter and
// falling-edge detector on the filtered level.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_i,
  output logic clk_filt,
  output logic fall_tick
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The filtered level only flips after FILTER_LEN consecutive differing samples.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    fall_d = 1'b0;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      filt_d = sync_q[1];
      fall_d = filt_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], ps2c_i};
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign clk_filt  = filt_q;
  assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter on open-collector ps2c/ps2d.
//   state | meaning
//   IDLE  | lines released, accepts wr_ps2
//   RTS   | host holds clock low (data low on the last cycle)
//   START | clock released, start bit on data, waiting for edge 1
//   DATA  | d0..d7 and parity presented after edges 1..9
//   ACK   | stop bit released, device ACK sampled on edge 11
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 13000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_ack_ok,
  output logic       tx_timeout_tick
);

  localparam int RW = $clog2(RTS_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [RW-1:0] rts_q, rts_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    edge_q, edge_d;
  logic          c_en_q, c_en_d, d_en_q, d_en_d;
  logic          ack_q, ack_d, done_q, done_d, tmo_tick_q, tmo_tick_d;
  logic [1:0]    dsync_q;
  logic          clk_filt, fall_tick, fall;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2c_i    (ps2c),
    .clk_filt  (clk_filt),
    .fall_tick (fall_tick)
  );

  assign fall = fall_tick & ~clk_filt;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rts_d      = rts_q;
    tmo_d      = tmo_q;
    edge_d     = edge_q;
    c_en_d     = c_en_q;
    d_en_d     = d_en_q;
    ack_d      = ack_q;
    done_d     = 1'b0;
    tmo_tick_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        c_en_d = 1'b0;
        d_en_d = 1'b0;
        if (wr_ps2) begin
          shift_d = {odd_parity(din), din};
          rts_d   = RW'(RTS_CYCLES - 1);
          c_en_d  = 1'b1;
          ack_d   = 1'b0;
          state_d = RTS;
        end
      end
      RTS: begin
        c_en_d = (rts_q != '0);
        d_en_d = (rts_q <= RW'(1));
        if (rts_q == '0) begin
          tmo_d   = TW'(1);
          edge_d  = '0;
          state_d = START;
        end else begin
          rts_d = rts_q - RW'(1);
        end
      end
      START, DATA, ACK: begin
        tmo_d = tmo_q + TW'(1);
        // Timeout takes priority over a coincident falling edge.
        if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          c_en_d     = 1'b0;
          d_en_d     = 1'b0;
          ack_d      = 1'b0;
          tmo_tick_d = 1'b1;
          state_d    = IDLE;
        end else if (fall) begin
          edge_d = (edge_q >= 4'(ACK_EDGE)) ? 4'(ACK_EDGE) : edge_q + 4'd1;
          if (state_q == START) begin
            d_en_d  = ~shift_q[0];
            state_d = DATA;
          end else if (state_q == DATA) begin
            if (edge_q == 4'(STOP_EDGE - 1)) begin
              d_en_d  = 1'b0;
              state_d = ACK;
            end else begin
              shift_d = shift_q >> 1;
              d_en_d  = ~shift_q[1];
            end
          end else begin
            ack_d   = ~dsync_q[1];
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        c_en_d  = 1'b0;
        d_en_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rts_q      <= '0;
      tmo_q      <= '0;
      edge_q     <= '0;
      c_en_q     <= 1'b0;
      d_en_q     <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      tmo_tick_q <= 1'b0;
      dsync_q    <= 2'b11;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rts_q      <= rts_d;
      tmo_q      <= tmo_d;
      edge_q     <= edge_d;
      c_en_q     <= c_en_d;
      d_en_q     <= d_en_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      tmo_tick_q <= tmo_tick_d;
      dsync_q    <= {dsync_q[0], ps2d};
    end
  end

  assign ps2c            = c_en_q ? 1'b0 : 1'bz;
  assign ps2d            = d_en_q ? 1'b0 : 1'bz;
  assign tx_idle         = (state_q == IDLE);
  assign tx_done_tick    = done_q;
  assign tx_ack_ok       = ack_q;
  assign tx_timeout_tick = tmo_tick_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and
// a transaction-level model predicts idle/tick/ack/line levels every cycle.
module tb_ps2_host_tx;

  localparam int RTS  = 20;
  localparam int FL   = 4;
  localparam int TMO  = 3000;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b0;
  logic       dev_d = 1'b0;
  wire        ps2c_w, ps2d_w;
  logic       tx_idle, tx_done_tick, tx_ack_ok, tx_timeout_tick;

  pullup (ps2c_w);
  pullup (ps2d_w);
  assign ps2c_w = dev_c ? 1'b0 : 1'bz;
  assign ps2d_w = dev_d ? 1'b0 : 1'bz;

  ps2_host_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_ps2          (wr_ps2),
    .din             (din),
    .ps2c            (ps2c_w),
    .ps2d            (ps2d_w),
    .tx_idle         (tx_idle),
    .tx_done_tick    (tx_done_tick),
    .tx_ack_ok       (tx_ack_ok),
    .tx_timeout_tick (tx_timeout_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int n_done = 0, n_tmo = 0, tmo_cyc = 0;
  bit cmp_en = 0;

  // Transaction model: accept cycle, end cycle, end kind (1 = done, 0 = timeout)
  bit m_busy = 0, m_kind = 0, m_ack_new = 0, m_ack_prev = 0;
  int m_acc = 0, m_end = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit in_txn(int c);
    return m_busy && c > m_acc && c < m_end;
  endfunction

  function automatic logic exp_ack(int c);
    if (!m_busy || c <= m_acc) return m_ack_prev;
    if (c < m_end) return 1'b0;
    return m_kind ? m_ack_new : 1'b0;
  endfunction

  always begin : cmp_proc
    int c;
    @(posedge clk);
    #1;
    if (cmp_en) begin
      c = cyc;
      chk("tx_idle", tx_idle, !in_txn(c));
      chk("tx_done_tick", tx_done_tick, m_busy && m_kind && c == m_end);
      chk("tx_timeout_tick", tx_timeout_tick, m_busy && !m_kind && c == m_end);
      chk("tx_ack_ok", tx_ack_ok, exp_ack(c));
      chk("ps2c_line", ps2c_w, ((m_busy && c > m_acc && c <= m_acc + RTS) || dev_c) ? 0 : 1);
      if (m_busy && c > m_acc && c <= m_acc + RTS + 1)
        chk("ps2d_rts", ps2d_w, (c >= m_acc + RTS) ? 0 : 1);
      else if (!in_txn(c) && !dev_d)
        chk("ps2d_idle", ps2d_w, 1);
      if (tx_done_tick) n_done++;
      if (tx_timeout_tick) begin
        n_tmo++;
        tmo_cyc = c;
      end
    end
  end

  task automatic send_req(input logic [7:0] b);
    @(negedge clk);
    if (!in_txn(cyc)) begin
      m_ack_prev = exp_ack(cyc);
      m_busy     = 1;
      m_acc      = cyc;
      m_end      = cyc + RTS + 1 + TMO;
      m_kind     = 0;
    end
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'h00;
  endtask

  // gmode 1: sub-threshold glitch in the high phase after edge 4
  // gmode 2: low phase of edge 4 shortened to FL+2 cycles
  task automatic dev_frame(input int n_edges, input bit ack_low, input int gmode,
                           output logic [10:0] bits, output int rts_len,
                           output logic d_at_rel, output int rel_cyc);
    int n, lowlen;
    bits = '1; rts_len = 0; d_at_rel = 1'b1; rel_cyc = 0;
    n = 0;
    while (ps2c_w !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("rts_seen", 0, 1);
      return;
    end
    while (ps2c_w === 1'b0 && rts_len < RTS + 50) begin
      @(negedge clk);
      rts_len++;
    end
    d_at_rel = ps2d_w;
    rel_cyc  = cyc;
    repeat (10) @(negedge clk);
    bits[0] = ps2d_w;
    for (int k = 1; k <= n_edges; k++) begin
      lowlen = (gmode == 2 && k == 4) ? FL + 2 : HALF;
      dev_c = 1'b1;
      if (k == 11) begin
        m_kind    = 1;
        m_end     = cyc + FL + 3;
        m_ack_new = ack_low;
      end
      repeat (lowlen) @(negedge clk);
      dev_c = 1'b0;
      if (k == 11) begin
        repeat (3) @(negedge clk);
        dev_d = 1'b0;
      end else begin
        if (gmode == 1 && k == 4) begin
          repeat (10) @(negedge clk);
          dev_c = 1'b1;
          repeat (FL - 1) @(negedge clk);
          dev_c = 1'b0;
          repeat (HALF - 10 - (FL - 1)) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        bits[k] = ps2d_w;
        if (k == 10 && ack_low) dev_d = 1'b1;
      end
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (cyc <= m_end + 1 && n < TMO + RTS + 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc <= m_end + 1) chk("end_wait", 0, 1);
  endtask

  task automatic check_frame(input logic [7:0] b, input logic [10:0] bits);
    chk("start_bit", bits[0], 0);
    chk("data_byte", bits[8:1], b);
    chk("parity_bit", bits[9], ($countones(b) % 2 == 0) ? 1 : 0);
    chk("stop_bit", bits[10], 1);
  endtask

  initial begin : wdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [10:0] bits;
    logic [8:0]  f4_bits;
    int          rl, rc, nd, nt;
    logic        dr;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_idle", tx_idle, 1);
    chk("rst_done", tx_done_tick, 0);
    chk("rst_ack", tx_ack_ok, 0);
    chk("rst_tmo", tx_timeout_tick, 0);
    chk("rst_ps2c", ps2c_w, 1);
    chk("rst_ps2d", ps2d_w, 1);
    cmp_en = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xF4 with device ACK
    fork
      send_req(8'hF4);
      dev_frame(11, 1, 0, bits, rl, dr, rc);
    join
    wait_end();
    check_frame(8'hF4, bits);
    f4_bits = 9'b0_1111_0100;
    for (int k = 1; k <= 9; k++) chk("f4_bit", bits[k], f4_bits[k-1]);
    chk("f4_ack_ok", tx_ack_ok, 1);

    // 0xFF: RTS length and data low at clock release
    repeat (20) @(negedge clk);
    fork
      send_req(8'hFF);
      dev_frame(11, 1, 0, bits, rl, dr, rc);
    join
    wait_end();
    check_frame(8'hFF, bits);
    chk("ff_parity", bits[9], 1);
    chk("ff_rts_len", rl, 20);
    chk("ff_d_at_release", dr, 0);

    // 0x00, device leaves data high for ACK
    repeat (20) @(negedge clk);
    fork
      send_req(8'h00);
      dev_frame(11, 0, 0, bits, rl, dr, rc);
    join
    wait_end();
    check_frame(8'h00, bits);
    chk("00_parity", bits[9], 1);
    chk("00_ack_ok", tx_ack_ok, 0);

    // device never clocks
    repeat (20) @(negedge clk);
    nd = n_done;
    nt = n_tmo;
    fork
      send_req(8'h5A);
      dev_frame(0, 0, 0, bits, rl, dr, rc);
    join
    wait_end();
    chk("to_tick_count", n_tmo, nt + 1);
    chk("to_no_done", n_done, nd);
    chk("to_latency", tmo_cyc - rc, 3000);
    chk("to_ps2c_z", ps2c_w, 1);
    chk("to_ps2d_z", ps2d_w, 1);
    chk("to_idle", tx_idle, 1);

    // request during DATA is ignored
    repeat (20) @(negedge clk);
    fork
      send_req(8'h3C);
      dev_frame(11, 1, 0, bits, rl, dr, rc);
      begin
        repeat (RTS + 200) @(negedge clk);
        send_req(8'hAA);
      end
    join
    wait_end();
    check_frame(8'h3C, bits);

    // short glitch ignored, short-but-valid low phase counted once
    repeat (20) @(negedge clk);
    fork
      send_req(8'h96);
      dev_frame(11, 1, 1, bits, rl, dr, rc);
    join
    wait_end();
    check_frame(8'h96, bits);
    repeat (20) @(negedge clk);
    fork
      send_req(8'h69);
      dev_frame(11, 1, 2, bits, rl, dr, rc);
    join
    wait_end();
    check_frame(8'h69, bits);

    // reset after edge 5 while the host is pulling data low (d4 of 0x0F = 0)
    repeat (20) @(negedge clk);
    fork
      send_req(8'h0F);
      dev_frame(5, 0, 0, bits, rl, dr, rc);
    join
    @(negedge clk);
    chk("mid_d4_low", ps2d_w, 0);
    rst_n      = 1'b0;
    m_busy     = 0;
    m_ack_prev = 0;
    #1;
    chk("mid_rst_ps2c", ps2c_w, 1);
    chk("mid_rst_ps2d", ps2d_w, 1);
    chk("mid_rst_idle", tx_idle, 1);
    chk("mid_rst_done", tx_done_tick, 0);
    chk("mid_rst_tmo", tx_timeout_tick, 0);
    chk("mid_rst_ack", tx_ack_ok, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // recovery frame after reset
    fork
      send_req(8'hA5);
      dev_frame(11, 1, 0, bits, rl, dr, rc);
    join
    wait_end();
    check_frame(8'hA5, bits);
    chk("a5_ack_ok", tx_ack_ok, 1);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
